// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: definitions shared by the memory stage and its
// condition decoder.
//   WORD_W        datapath width for addresses, store data and writeback values
//   CNT_W         width of the dmem_ready wait counter (covers TIMEOUT 1..255)
//   state_t       memory-stage FSM encoding (IDLE / ACCESS / DONE)
//   CC_*          B.cond condition-field encodings
//   is_aligned()  doubleword alignment test on a data address
package memory_stage_pkg;

  localparam int WORD_W = 64;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_HS = 4'h2;
  localparam logic [3:0] CC_LO = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Data accesses are doubleword-wide, so the low three address bits must be 0.
  function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
    return (addr[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational B.cond condition decoder.
//   cond_code  in   4-bit condition field
//   n, z, c, v in   status flags (negative, zero, carry, overflow)
//   cond_true  out  1 when the condition holds for the given flags
module cond_eval
  import memory_stage_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      CC_EQ: cond_true = z;
      CC_NE: cond_true = ~z;
      CC_HS: cond_true = c;
      CC_LO: cond_true = ~c;
      CC_MI: cond_true = n;
      CC_PL: cond_true = ~n;
      CC_VS: cond_true = v;
      CC_VC: cond_true = ~v;
      CC_HI: cond_true = c & ~z;
      CC_LS: cond_true = ~(c & ~z);
      CC_GE: cond_true = (n == v);
      CC_LT: cond_true = (n != v);
      CC_GT: cond_true = ~z & (n == v);
      CC_LE: cond_true = ~(~z & (n == v));
      CC_AL, CC_NV: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: memory-access stage of the pipeline. Passes ALU results to
// writeback, performs doubleword loads/stores over a ready-handshake data
// bus with a bounded wait, and resolves branches.
//   clk, reset                 clock / asynchronous active-high reset
//   valid_in                   execute-stage operands valid (accepted in IDLE only)
//   alu_result                 data address (mem op) or writeback value
//   branch_target, write_data  branch target / store data
//   mem_read, mem_write, mem_to_reg           memory control bits
//   uncond_branch, cbz_branch, cond_branch    branch type; cond_code B.cond field
//   zero, negative, overflow, carry           status flags
//   dmem_req, dmem_we, dmem_addr, dmem_wdata  data-bus request (held during ACCESS)
//   dmem_ready, dmem_rdata                    data-bus completion / load data
//   stall                      upstream must hold its operands
//   wb_valid, wb_data          one-cycle writeback pulse and value
//   pc_src, pc_target          one-cycle branch-taken pulse and target
//   align_fault, bus_fault     one-cycle fault pulses
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int DATA_W  = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              uncond_branch,
  input  logic              cbz_branch,
  input  logic              cond_branch,
  input  logic [3:0]        cond_code,
  input  logic              zero,
  input  logic              negative,
  input  logic              overflow,
  input  logic              carry,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              align_fault,
  output logic              bus_fault
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_q;
  state_t            state_d;

  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              rd_p1;
  logic              we_p1;
  logic              to_reg_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [DATA_W-1:0] rdata_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] wb_data_p2;
  logic              pc_src_p2;
  logic [DATA_W-1:0] pc_target_p2;
  logic              align_fault_p2;
  logic              bus_fault_p2;

  logic              accept;
  logic              mem_op;
  logic              aligned;
  logic              in_access;
  logic              last_wait;
  logic              cond_true;
  logic              take_branch;

  cond_eval u_cond_eval (
    .cond_code (cond_code),
    .n         (negative),
    .z         (zero),
    .c         (carry),
    .v         (overflow),
    .cond_true (cond_true)
  );

  assign mem_op      = valid_in & (mem_read | mem_write);
  assign aligned     = is_aligned(alu_result);
  assign accept      = (state_q == ST_IDLE) & valid_in;
  assign in_access   = (state_q == ST_ACCESS);
  // The wait that would bring the counter up to TIMEOUT is the last one allowed.
  assign last_wait   = (cnt_p1 == (TIMEOUT_C - CNT_W'(1)));
  assign take_branch = uncond_branch | (cbz_branch & zero) | (cond_branch & cond_true);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_op & aligned) begin
          state_d = ST_ACCESS;
        end
        // Gated by reset so the combinational path cannot leak a stall
        // while the stage is held in reset.
        stall = ~reset & mem_op & aligned;
      end
      ST_ACCESS: begin
        if (dmem_ready) begin
          state_d = ST_DONE;
        end else if (last_wait) begin
          state_d = ST_IDLE;
        end
        stall = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stall   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (in_access) begin
      dmem_req   = 1'b1;
      dmem_we    = we_p1;
      dmem_addr  = addr_p1;
      dmem_wdata = wdata_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p1        <= '0;
      wdata_p1       <= '0;
      rd_p1          <= 1'b0;
      we_p1          <= 1'b0;
      to_reg_p1      <= 1'b0;
      cnt_p1         <= '0;
      rdata_p1       <= '0;
      vld_p2         <= 1'b0;
      wb_data_p2     <= '0;
      pc_src_p2      <= 1'b0;
      pc_target_p2   <= '0;
      align_fault_p2 <= 1'b0;
      bus_fault_p2   <= 1'b0;
    end else begin
      vld_p2         <= 1'b0;
      pc_src_p2      <= 1'b0;
      align_fault_p2 <= 1'b0;
      bus_fault_p2   <= 1'b0;

      // ---- stage p0 -> p1/p2: accept execute-stage operands in IDLE ----
      if (accept) begin
        pc_src_p2    <= take_branch;
        pc_target_p2 <= branch_target;
        if (!mem_op) begin
          vld_p2     <= 1'b1;
          wb_data_p2 <= alu_result;
        end else if (aligned) begin
          addr_p1   <= alu_result;
          wdata_p1  <= write_data;
          rd_p1     <= mem_read;
          we_p1     <= mem_write;
          to_reg_p1 <= mem_to_reg;
          cnt_p1    <= '0;
        end else begin
          align_fault_p2 <= 1'b1;
        end
      end

      // ---- stage p1: bus access, bounded wait on dmem_ready ----
      if (in_access) begin
        if (dmem_ready) begin
          if (rd_p1) begin
            rdata_p1 <= dmem_rdata;
          end
        end else begin
          cnt_p1 <= cnt_p1 + CNT_W'(1);
          if (last_wait) begin
            bus_fault_p2 <= 1'b1;
          end
        end
      end

      // ---- stage p1 -> p2: report load completion to writeback ----
      if ((state_q == ST_DONE) && to_reg_p1) begin
        vld_p2     <= 1'b1;
        wb_data_p2 <= rdata_p1;
      end
    end
  end

  assign wb_valid    = vld_p2;
  assign wb_data     = wb_data_p2;
  assign pc_src      = pc_src_p2;
  assign pc_target   = pc_target_p2;
  assign align_fault = align_fault_p2;
  assign bus_fault   = bus_fault_p2;

endmodule
